eh2_iccm_arb: RTL

- Single-port access controller in front of the ICCM macro port (rw_addr/rden/wren/wr_size/wr_data).
- Shares that port between three requesters:
  - ECC single-bit correction writeback (highest priority)
  - IFU fetch reads
  - DMA reads and writes
- Sequences read-modify-write (RMW) for DMA byte and halfword writes, regenerating ECC on the merged data.
- Sits between IFU/DMA control and the ICCM macro in the mem wrapper hierarchy.

---
 rtl/eh2_pkg.sv | 38 +++
 rtl/eh2_iccm_ecc_gen.sv | 23 ++
 rtl/eh2_iccm_arb.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/eh2_pkg.sv
// Shared types and constants for the ICCM access arbiter.
// Holds the RMW state encoding, the DMA size encoding, the SECDED widths
// and two small helpers used by the arbiter datapath.
package eh2_pkg;

    localparam int ECC_W     = 7;
    localparam int HALF_W    = 32 + ECC_W;
    localparam int ICCM_WR_W = 2 * HALF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        MERGE = 2'd2,
        WR    = 2'd3
    } rmw_state_e;

    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_HALF  = 3'd1,
        SZ_WORD  = 3'd2,
        SZ_DWORD = 3'd3
    } dma_size_e;

    // Byte lanes of the 64-bit row touched by a sub-word write; a halfword
    // at an odd address is aligned down to its even lane pair.
    function automatic logic [7:0] rmw_byte_en(input dma_size_e size, input logic [2:0] off);
        logic [7:0] be;
        if (size == SZ_HALF) be = 8'b0000_0011 << {off[2:1], 1'b0};
        else                 be = 8'b0000_0001 << off;
        return be;
    endfunction

    // Event counter that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic ev);
        return (ev && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/eh2_iccm_ecc_gen.sv
// Combinational 32-bit SECDED encoder: six Hamming check bits plus one
// overall parity bit over data and check bits (39,32 code).
module eh2_iccm_ecc_gen
    import eh2_pkg::*;
(
    input  logic [31:0]      din,
    output logic [ECC_W-1:0] ecc
);

    logic [5:0] chk;

    // Each mask selects the data bits whose codeword position has that check bit set
    always_comb begin
        chk[0] = ^(din & 32'h56AA_AD5B);
        chk[1] = ^(din & 32'h9B33_366D);
        chk[2] = ^(din & 32'hE3C3_C78E);
        chk[3] = ^(din & 32'h03FC_07F0);
        chk[4] = ^(din & 32'h03FF_F800);
        chk[5] = ^(din & 32'hFC00_0000);
        ecc    = {^{din, chk}, chk};
    end

endmodule

// File: rtl/eh2_iccm_arb.sv
// Single-port ICCM access arbiter: correction writeback > DMA/fetch with a
// starvation counter that eventually lets DMA beat fetch. DMA byte/halfword
// writes run an atomic read-modify-write (RD, MERGE, WR) with fresh ECC.
// Optional build macro ICCM_ARB_PERF_EN adds saturating grant/stall counters.
module eh2_iccm_arb
    import eh2_pkg::*;
#(
    parameter int ICCM_BITS      = 16,
    parameter int NUM_THREADS    = 2,
    parameter int DMA_STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic                 fetch_tid,
    input  logic [ICCM_BITS-1:1] fetch_addr,
    output logic                 fetch_gnt,
    input  logic                 dma_req,
    input  logic                 dma_wr,
    input  logic [2:0]           dma_size,
    input  logic [ICCM_BITS-1:0] dma_addr,
    input  logic [63:0]          dma_wdata,
    output logic                 dma_gnt,
    output logic                 dma_rvalid,
    output logic [63:0]          dma_rdata,
    input  logic                 corr_req,
    input  logic [ICCM_BITS-1:1] corr_addr,
    input  logic [ICCM_WR_W-1:0] corr_wdata,
    output logic                 corr_done,
    output logic [ICCM_BITS-1:1] iccm_rw_addr,
    output logic                 iccm_rden,
    output logic                 iccm_wren,
    output logic [2:0]           iccm_wr_size,
    output logic [ICCM_WR_W-1:0] iccm_wr_data,
    input  logic [63:0]          iccm_rd_data,
`ifdef ICCM_ARB_PERF_EN
    output logic [31:0]          fetch_gnt_cnt,
    output logic [31:0]          dma_gnt_cnt,
    output logic [31:0]          rmw_cnt,
    output logic [31:0]          fetch_stall_cnt,
`endif
    output logic                 busy
);

    localparam logic [3:0] STARVE_MAX = 4'(DMA_STARVE_MAX);

    rmw_state_e           state_q, state_d;
    logic [3:0]           starve_q, starve_d;
    logic                 dma_rvalid_q, dma_rvalid_d;
    logic [ICCM_BITS-1:1] rmw_addr_q, rmw_addr_d;
    logic [7:0]           rmw_be_q, rmw_be_d;
    logic [63:0]          rmw_wdata_q, rmw_wdata_d;
    logic [63:0]          merge_q, merge_d;
    logic [ICCM_WR_W-1:0] wr_data_q, wr_data_d;

    dma_size_e            dma_size_t;
    logic                 idle, corr_win, dma_win, fetch_win, dma_is_rmw;
    logic [ICCM_BITS-1:0] dma_addr_al;
    logic [63:0]          ecc_din;
    logic [ECC_W-1:0]     ecc_lo, ecc_hi;
    logic [ICCM_WR_W-1:0] ecc_word;
    logic                 unused_ok;

    assign dma_size_t = dma_size_e'(dma_size);
    assign unused_ok  = ^{fetch_tid, dma_addr_al[0], (NUM_THREADS > 1)};

    // One encoder pair serves both direct DMA writes (IDLE) and the RMW merge (MERGE)
    assign ecc_din  = (state_q == MERGE) ? merge_q : dma_wdata;
    assign ecc_word = {ecc_hi, ecc_din[63:32], ecc_lo, ecc_din[31:0]};

    eh2_iccm_ecc_gen u_ecc_lo (.din(ecc_din[31:0]),  .ecc(ecc_lo));
    eh2_iccm_ecc_gen u_ecc_hi (.din(ecc_din[63:32]), .ecc(ecc_hi));

    // Misaligned DMA accesses are aligned down to their natural size
    always_comb begin
        dma_addr_al = dma_addr;
        case (dma_size_t)
            SZ_BYTE: dma_addr_al = dma_addr;
            SZ_HALF: dma_addr_al[0]   = 1'b0;
            SZ_WORD: dma_addr_al[1:0] = 2'b00;
            default: dma_addr_al[2:0] = 3'b000;
        endcase
    end

    // Winner selection; only IDLE arbitrates, RMW states hold the port
    always_comb begin
        idle       = (state_q == IDLE) && !rst;
        corr_win   = idle && corr_req;
        dma_win    = idle && !corr_req && dma_req && ((starve_q == STARVE_MAX) || !fetch_req);
        fetch_win  = idle && !corr_req && !dma_win && fetch_req;
        dma_is_rmw = dma_wr && ((dma_size_t == SZ_BYTE) || (dma_size_t == SZ_HALF));
    end

    // Drive the macro port and grant pulses from this cycle's owner
    always_comb begin
        iccm_rw_addr = '0;
        iccm_rden    = 1'b0;
        iccm_wren    = 1'b0;
        iccm_wr_size = 3'd0;
        iccm_wr_data = '0;
        fetch_gnt    = 1'b0;
        dma_gnt      = 1'b0;
        corr_done    = 1'b0;
        if ((state_q == WR) && !rst) begin
            iccm_wren    = 1'b1;
            iccm_rw_addr = rmw_addr_q;
            iccm_wr_size = 3'(SZ_DWORD);
            iccm_wr_data = wr_data_q;
        end else if (corr_win) begin
            corr_done    = 1'b1;
            iccm_wren    = 1'b1;
            iccm_rw_addr = corr_addr;
            iccm_wr_size = 3'(SZ_DWORD);
            iccm_wr_data = corr_wdata;
        end else if (dma_win) begin
            dma_gnt = 1'b1;
            if (dma_is_rmw) begin
                iccm_rden    = 1'b1;
                iccm_rw_addr = {dma_addr[ICCM_BITS-1:3], 2'b00};
            end else if (dma_wr) begin
                iccm_wren    = 1'b1;
                iccm_rw_addr = dma_addr_al[ICCM_BITS-1:1];
                iccm_wr_size = dma_size;
                iccm_wr_data = ecc_word;
            end else begin
                iccm_rden    = 1'b1;
                iccm_rw_addr = dma_addr_al[ICCM_BITS-1:1];
            end
        end else if (fetch_win) begin
            fetch_gnt    = 1'b1;
            iccm_rden    = 1'b1;
            iccm_rw_addr = fetch_addr;
        end
    end

    // Next-state: RMW sequencing, starvation count and read-return tracking
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_be_d     = rmw_be_q;
        rmw_wdata_d  = rmw_wdata_q;
        merge_d      = merge_q;
        wr_data_d    = wr_data_q;
        dma_rvalid_d = dma_win && !dma_wr;

        if (!dma_req || dma_win)
            starve_d = '0;
        else if ((corr_win || fetch_win) && (starve_q != STARVE_MAX))
            starve_d = starve_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (dma_win && dma_is_rmw) begin
                    state_d     = RD;
                    rmw_addr_d  = {dma_addr[ICCM_BITS-1:3], 2'b00};
                    rmw_be_d    = rmw_byte_en(dma_size_t, dma_addr[2:0]);
                    rmw_wdata_d = dma_wdata;
                end
            end
            RD: begin
                state_d = MERGE;
                for (int b = 0; b < 8; b++)
                    merge_d[8*b +: 8] = rmw_be_q[b] ? rmw_wdata_q[8*b +: 8] : iccm_rd_data[8*b +: 8];
            end
            MERGE: begin
                state_d   = WR;
                wr_data_d = ecc_word;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight RMW without writing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            dma_rvalid_q <= 1'b0;
            rmw_addr_q   <= '0;
            rmw_be_q     <= '0;
            rmw_wdata_q  <= '0;
            merge_q      <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            dma_rvalid_q <= dma_rvalid_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_be_q     <= rmw_be_d;
            rmw_wdata_q  <= rmw_wdata_d;
            merge_q      <= merge_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign busy       = (state_q != IDLE) && !rst;
    assign dma_rvalid = dma_rvalid_q && !rst;
    assign dma_rdata  = dma_rvalid ? iccm_rd_data : '0;

`ifdef ICCM_ARB_PERF_EN
    logic [31:0] fetch_gnt_cnt_q, fetch_gnt_cnt_d;
    logic [31:0] dma_gnt_cnt_q, dma_gnt_cnt_d;
    logic [31:0] rmw_cnt_q, rmw_cnt_d;
    logic [31:0] fetch_stall_cnt_q, fetch_stall_cnt_d;

    // Saturating event counts
    always_comb begin
        fetch_gnt_cnt_d   = sat_inc32(fetch_gnt_cnt_q, fetch_gnt);
        dma_gnt_cnt_d     = sat_inc32(dma_gnt_cnt_q, dma_gnt);
        rmw_cnt_d         = sat_inc32(rmw_cnt_q, dma_win && dma_is_rmw);
        fetch_stall_cnt_d = sat_inc32(fetch_stall_cnt_q, fetch_req && !fetch_gnt && !rst);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_gnt_cnt_q   <= '0;
            dma_gnt_cnt_q     <= '0;
            rmw_cnt_q         <= '0;
            fetch_stall_cnt_q <= '0;
        end else begin
            fetch_gnt_cnt_q   <= fetch_gnt_cnt_d;
            dma_gnt_cnt_q     <= dma_gnt_cnt_d;
            rmw_cnt_q         <= rmw_cnt_d;
            fetch_stall_cnt_q <= fetch_stall_cnt_d;
        end
    end

    assign fetch_gnt_cnt   = fetch_gnt_cnt_q;
    assign dma_gnt_cnt     = dma_gnt_cnt_q;
    assign rmw_cnt         = rmw_cnt_q;
    assign fetch_stall_cnt = fetch_stall_cnt_q;
`endif

endmodule
